// File: rtl/fsm_div_driver.sv
// fsm_div_driver: initiator for the fsm_div operand protocol.
// Latches four 4-bit operands on start, sends them to the responder as
// single-cycle strobes in the order a, b, c, d (each followed by GAP_CYCLES
// idle cycles), then waits up to TIMEOUT cycles for the result strobe.
// Optional build macro: FSM_DIV_DRIVER_PRECHECK_EN -- when defined, a start
// with a==0 or b==0 completes at once with err=1 and sends no operands.
//
// Handshake: dut_valid_in is a one-cycle strobe with no back-pressure; the
// responder must take dut_d_in in every cycle dut_valid_in is high. Likewise
// dut_valid_out is a one-cycle strobe that is only honoured in WAIT and is
// dropped in every other state.
module fsm_div_driver #(
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  output logic       busy,
  output logic       done,
  output logic [3:0] res,
  output logic       err,
  output logic       timeout,
  output logic [3:0] dut_d_in,
  output logic       dut_valid_in,
  input  logic [3:0] dut_d_out,
  input  logic       dut_valid_out,
  input  logic       dut_error_out,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_GAP  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // One counter serves both the GAP length and the WAIT budget.
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t          state_q;
  logic [1:0]      idx_q;
  logic [1:0]      idx_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [3:0]      op_q [4];
  logic            busy_q;
  logic            done_q;
  logic [3:0]      res_q;
  logic            err_q;
  logic            timeout_q;
  logic [3:0]      dut_d_in_q;
  logic            dut_valid_in_q;

  // Next operand index and next counter value used by the FSM below.
  always_comb begin
    idx_d = idx_q + 2'd1;
    cnt_d = cnt_q + 1'b1;
  end

  // Sequencer: all outputs are registered and reflect the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= 2'd0;
      cnt_q          <= '0;
      for (int i = 0; i < 4; i++) op_q[i] <= 4'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      res_q          <= 4'd0;
      err_q          <= 1'b0;
      timeout_q      <= 1'b0;
      dut_d_in_q     <= 4'd0;
      dut_valid_in_q <= 1'b0;
    end else begin
      // Strobes default low; only the transitions below raise them.
      done_q         <= 1'b0;
      dut_valid_in_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q[0] <= a;
            op_q[1] <= b;
            op_q[2] <= c;
            op_q[3] <= d;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
`ifdef FSM_DIV_DRIVER_PRECHECK_EN
            if (a == 4'd0 || b == 4'd0) begin
              // Known-bad operands: report the error without touching fsm_div.
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              res_q     <= 4'd0;
              err_q     <= 1'b1;
              timeout_q <= 1'b0;
            end else begin
              state_q        <= S_SEND;
              dut_valid_in_q <= 1'b1;
              dut_d_in_q     <= a;
            end
`else
            state_q        <= S_SEND;
            dut_valid_in_q <= 1'b1;
            dut_d_in_q     <= a;
`endif
          end
        end
        S_SEND: begin
          state_q <= S_GAP;
          cnt_q   <= '0;
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (idx_q == 2'd3) begin
              state_q <= S_WAIT;
            end else begin
              idx_q          <= idx_d;
              state_q        <= S_SEND;
              dut_valid_in_q <= 1'b1;
              dut_d_in_q     <= op_q[idx_d];
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT: begin
          // A response on the last allowed cycle still wins over the timeout.
          if (dut_valid_out) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            res_q     <= dut_d_out;
            err_q     <= dut_error_out;
            timeout_q <= 1'b0;
          end else if (cnt_q == WAIT_LAST) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            res_q     <= 4'd0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign res          = res_q;
  assign err          = err_q;
  assign timeout      = timeout_q;
  assign dut_d_in     = dut_d_in_q;
  assign dut_valid_in = dut_valid_in_q;
  assign dbg_state    = state_q;

endmodule
